fifo_128_out_fwft: RTL

Single-clock 128-bit output FIFO carrying user-logic results toward the PicoBus host read path. It complements the host-to-user input FIFO.
- Built in RTL over inferred block RAM.
- Provides true first-word-fall-through in synchronous mode, so no flag OR-ing across hard FIFO primitives is needed.
- Writer is user logic; reader is the bus-side stream engine.

---
 rtl/pico_fifo_pkg.sv | 20 ++
 rtl/fifo_128_out_fwft_if.sv | 35 +++
 rtl/sdp_ram_128.sv | 29 ++
 rtl/fifo_128_out_fwft.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/pico_fifo_pkg.sv
// Shared constants and helpers for the PicoBus stream FIFOs.
// Defines the data and parity widths and the odd byte-parity generator.
package pico_fifo_pkg;

  localparam int DATA_W = 128;
  localparam int PAR_W  = 16;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [PAR_W-1:0]  par_t;

  // Each byte together with its parity bit carries an odd number of ones.
  function automatic par_t odd_byte_parity(input data_t d);
    par_t p;
    for (int i = 0; i < PAR_W; i++) begin
      p[i] = ~(^d[8*i +: 8]);
    end
    return p;
  endfunction

endpackage

// File: rtl/fifo_128_out_fwft_if.sv
// Write/read stream interface of the 128-bit output FIFO.
// The slave modport is the FIFO side and the master modport is the user/bus side.
interface fifo_128_out_fwft_if #(
  parameter int DEPTH = 512
);
  import pico_fifo_pkg::*;

  data_t                 din;
  par_t                  dinp;
  logic                  wr_en;
  logic                  full;
  logic                  prog_full;
  data_t                 dout;
  par_t                  doutp;
  logic                  valid;
  logic                  empty;
  logic                  rd_en;
  logic                  prog_empty;
  logic [$clog2(DEPTH):0] count;
  logic                  overflow;
  logic                  underflow;

  modport slave (
    input  din, dinp, wr_en, rd_en,
    output full, prog_full, dout, doutp, valid, empty, prog_empty, count,
           overflow, underflow
  );

  modport master (
    output din, dinp, wr_en, rd_en,
    input  full, prog_full, dout, doutp, valid, empty, prog_empty, count,
           overflow, underflow
  );

endinterface

// File: rtl/sdp_ram_128.sv
// Simple dual-port RAM with a registered read port; maps onto block RAM.
// The read register holds its value while re_i is low.
module sdp_ram_128
  import pico_fifo_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int W     = DATA_W + PAR_W
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/fifo_128_out_fwft.sv
// Single-clock 128-bit first-word-fall-through output FIFO over block RAM.
// PICO_OUT_PARITY_GEN_EN: generate odd byte parity at the output instead of storing dinp.
module fifo_128_out_fwft
  import pico_fifo_pkg::*;
#(
  parameter int DEPTH               = 512,
  parameter int ALMOST_FULL_OFFSET  = 16,
  parameter int ALMOST_EMPTY_OFFSET = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_128_out_fwft_if.slave bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
`ifdef PICO_OUT_PARITY_GEN_EN
  localparam int RAM_W = DATA_W;
`else
  localparam int RAM_W = DATA_W + PAR_W;
`endif

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] ram_words;
  logic             pf_valid_q, pf_valid_d;
  logic             valid_q, valid_d;
  data_t            dout_q, dout_d;
  par_t             doutp_q, doutp_d;
  logic             full_q, full_d;
  logic             prog_full_q, prog_full_d;
  logic             prog_empty_q, prog_empty_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             wr_acc, rd_acc, pf_move, ram_re;
  logic [RAM_W-1:0] ram_wdata, ram_rdata;

`ifdef PICO_OUT_PARITY_GEN_EN
  assign ram_wdata = bus.din;
`else
  assign ram_wdata = {bus.dinp, bus.din};
`endif

  sdp_ram_128 #(
    .DEPTH (DEPTH),
    .W     (RAM_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    wr_acc    = bus.wr_en & ~full_q;
    rd_acc    = bus.rd_en & valid_q;
    // Words still sitting in RAM: everything counted minus what the two stages hold.
    ram_words = count_q - CNT_W'(pf_valid_q) - CNT_W'(valid_q);
    pf_move   = pf_valid_q & (~valid_q | rd_acc);
    ram_re    = (ram_words != '0) & (~pf_valid_q | pf_move);

    wr_ptr_d  = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = ram_re ? rd_ptr_q + 1'b1 : rd_ptr_q;

    pf_valid_d = pf_valid_q;
    if (ram_re) begin
      pf_valid_d = 1'b1;
    end else if (pf_move) begin
      pf_valid_d = 1'b0;
    end

    valid_d = valid_q;
    dout_d  = dout_q;
    doutp_d = doutp_q;
    if (pf_move) begin
      valid_d = 1'b1;
      dout_d  = ram_rdata[DATA_W-1:0];
`ifdef PICO_OUT_PARITY_GEN_EN
      doutp_d = odd_byte_parity(ram_rdata[DATA_W-1:0]);
`else
      doutp_d = ram_rdata[DATA_W +: PAR_W];
`endif
    end else if (rd_acc) begin
      valid_d = 1'b0;
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    full_d       = (count_d == CNT_W'(DEPTH));
    prog_full_d  = (count_d >= CNT_W'(DEPTH - ALMOST_FULL_OFFSET));
    prog_empty_d = (count_d <= CNT_W'(ALMOST_EMPTY_OFFSET));
    overflow_d   = overflow_q  | (bus.wr_en & full_q);
    underflow_d  = underflow_q | (bus.rd_en & ~valid_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pf_valid_q   <= 1'b0;
      valid_q      <= 1'b0;
      dout_q       <= '0;
      doutp_q      <= '0;
      full_q       <= 1'b0;
      prog_full_q  <= 1'b0;
      prog_empty_q <= 1'b1;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pf_valid_q   <= pf_valid_d;
      valid_q      <= valid_d;
      dout_q       <= dout_d;
      doutp_q      <= doutp_d;
      full_q       <= full_d;
      prog_full_q  <= prog_full_d;
      prog_empty_q <= prog_empty_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  assign bus.full       = full_q;
  assign bus.prog_full  = prog_full_q;
  assign bus.dout       = dout_q;
  assign bus.doutp      = doutp_q;
  assign bus.valid      = valid_q;
  assign bus.empty      = ~valid_q;
  assign bus.prog_empty = prog_empty_q;
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.underflow  = underflow_q;

endmodule
